// File: rtl/elixirchip_es1_spu_mul_sharer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_mul_sharer_pkg
//  Brief    : Shared definitions for the SPU multiplier sharer (ID width
//             helper, statistics counter saturation limit).
//  Revision : 1.0 - initial release
// ============================================================================
package elixirchip_es1_spu_mul_sharer_pkg;

    // Saturation value of the per-requester issue counters
    localparam logic [31:0] c_stat_sat_limit = 32'hFFFF_FFFF;

    // Width of a requester index; never narrower than one bit
    function automatic int calc_id_bits(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elixirchip_es1_spu_op_mulu.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_op_mulu
//  Brief    : Pipelined unsigned multiplier (DSP form). Input register,
//             product register, then LATENCY-2 delay stages. The full product
//             is shifted right by DATA_SHIFT and truncated to M_DATA_BITS.
//  Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_op_mulu #(
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 8,
    parameter int DATA_SHIFT   = 0,
    parameter int LATENCY      = 3,
    parameter int USE_VALID    = 1,
    parameter int USE_CLEAR    = 0,
    parameter     DEVICE       = "RTL",
    parameter     SIMULATION   = "false",
    parameter     DEBUG        = "false"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,
    input  logic [S_DATA0_BITS-1:0] s_data0,
    input  logic [S_DATA1_BITS-1:0] s_data1,
    input  logic                    s_valid,
    input  logic                    s_clear,
    output logic [M_DATA_BITS-1:0]  m_data,
    output logic                    m_valid
);

    localparam int c_prod_bits = S_DATA0_BITS + S_DATA1_BITS;
    // Generic targets and simulation builds clear the datapath for determinism
    localparam bit c_reset_data = (DEVICE == "RTL") || (SIMULATION == "true");

    logic [S_DATA0_BITS-1:0]                 r_a;
    logic [S_DATA1_BITS-1:0]                 r_b;
    logic [LATENCY-2:0][c_prod_bits-1:0]     r_prod;

    // Operand register, multiply stage and product delay line
    always_ff @(posedge clk) begin
        if (reset && c_reset_data) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else if (cke) begin
            r_a    <= s_data0;
            r_b    <= s_data1;
            r_prod <= {r_prod[LATENCY-3:0], c_prod_bits'(r_a) * c_prod_bits'(r_b)};
        end
    end

    assign m_data = M_DATA_BITS'(r_prod[LATENCY-2] >> DATA_SHIFT);

    generate
        if (USE_VALID != 0) begin : g_valid
            logic [LATENCY-1:0] r_vld;
            // Valid travels alongside the data; optional clear flushes it
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                end else if (cke) begin
                    r_vld <= ((USE_CLEAR != 0) && s_clear) ? '0 : {r_vld[LATENCY-2:0], s_valid};
                end
            end
            assign m_valid = r_vld[LATENCY-1];
        end else begin : g_no_valid
            assign m_valid = 1'b1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/elixirchip_es1_spu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_rr_arbiter
//  Brief    : Round-robin arbiter. Grant is combinational from request,
//             searching upward from ptr. On an accept, ptr moves to one past
//             the granted requester. accept must be a subset of grant.
//  Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_rr_arbiter
    import elixirchip_es1_spu_mul_sharer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = calc_id_bits(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cke,
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_BITS-1:0] grant_id
);

    logic [ID_BITS-1:0] r_ptr;
    logic               w_found;

    // First active request at or after ptr, wrapping around
    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && request[(int'(r_ptr) + k) % NUM_REQ]) begin
                grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
                grant_id = ID_BITS'((int'(r_ptr) + k) % NUM_REQ);
                w_found  = 1'b1;
            end
        end
    end

    // Pointer advances past the winner only when the grant is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (cke && (|accept)) begin
            r_ptr <= (grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/elixirchip_es1_spu_mul_sharer.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_mul_sharer
//  Brief    : Shares one pipelined unsigned multiplier among NUM_REQ
//             requesters. Round-robin grant, ID tagged through the pipeline,
//             one-hot result valid. Accept at T gives m_valid at T+LATENCY+2.
//             Optional macro ELIXIRCHIP_ES1_SPU_MUL_SHARER_STAT_EN adds
//             saturating per-requester issue counters (m_issue_count).
//  Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_mul_sharer
    import elixirchip_es1_spu_mul_sharer_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LATENCY      = 3,
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 8,
    parameter int DATA_SHIFT   = 0,
    parameter     DEVICE       = "RTL",
    parameter     SIMULATION   = "false",
    parameter     DEBUG        = "false",
    localparam int ID_BITS     = calc_id_bits(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cke,
    input  logic [NUM_REQ-1:0][S_DATA0_BITS-1:0]  s_data0,
    input  logic [NUM_REQ-1:0][S_DATA1_BITS-1:0]  s_data1,
    input  logic [NUM_REQ-1:0]                    s_valid,
    output logic [NUM_REQ-1:0]                    s_ready,
    output logic [M_DATA_BITS-1:0]                m_data,
    output logic [ID_BITS-1:0]                    m_id,
    output logic [NUM_REQ-1:0]                    m_valid
`ifdef ELIXIRCHIP_ES1_SPU_MUL_SHARER_STAT_EN
    ,
    output logic [NUM_REQ-1:0][31:0]              m_issue_count
`endif
);

    // Issue-stage payload: operands, owner ID and valid flag
    typedef struct packed {
        logic [S_DATA0_BITS-1:0] data0;
        logic [S_DATA1_BITS-1:0] data1;
        logic [ID_BITS-1:0]      id;
        logic                    valid;
    } issue_t;

    logic [NUM_REQ-1:0]               w_grant;
    logic [NUM_REQ-1:0]               w_accept;
    logic [ID_BITS-1:0]               w_grant_id;
    issue_t                           r_issue;
    logic [M_DATA_BITS-1:0]           w_mul_data;
    logic                             w_mul_valid;
    logic [LATENCY-1:0][ID_BITS-1:0]  r_id_pipe;
    logic [LATENCY-1:0]               r_vld_pipe;
    logic                             w_tag_valid;

    // Nothing is granted while frozen or in reset, so an accept is always real
    assign s_ready  = w_grant & {NUM_REQ{cke & ~reset}};
    assign w_accept = s_valid & s_ready;

    elixirchip_es1_spu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .cke      (cke),
        .request  (s_valid),
        .accept   (w_accept),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    // Issue register: latch the winner's operands; valid only on an accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue <= '0;
        end else if (cke) begin
            r_issue.data0 <= s_data0[w_grant_id];
            r_issue.data1 <= s_data1[w_grant_id];
            r_issue.id    <= w_grant_id;
            r_issue.valid <= |w_accept;
        end
    end

    elixirchip_es1_spu_op_mulu #(
        .S_DATA0_BITS (S_DATA0_BITS),
        .S_DATA1_BITS (S_DATA1_BITS),
        .M_DATA_BITS  (M_DATA_BITS),
        .DATA_SHIFT   (DATA_SHIFT),
        .LATENCY      (LATENCY),
        .USE_VALID    (1),
        .USE_CLEAR    (0),
        .DEVICE       (DEVICE),
        .SIMULATION   (SIMULATION),
        .DEBUG        (DEBUG)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_data0 (r_issue.data0),
        .s_data1 (r_issue.data1),
        .s_valid (r_issue.valid),
        .s_clear (1'b0),
        .m_data  (w_mul_data),
        .m_valid (w_mul_valid)
    );

    // ID/valid tag pipeline, matched to the multiplier latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_pipe  <= '0;
            r_vld_pipe <= '0;
        end else if (cke) begin
            r_id_pipe  <= {r_id_pipe[LATENCY-2:0], r_issue.id};
            r_vld_pipe <= {r_vld_pipe[LATENCY-2:0], r_issue.valid};
        end
    end

    // Both valids are in lock-step; combining them guards against a tag slip
    assign w_tag_valid = r_vld_pipe[LATENCY-1] & w_mul_valid;

    // Output register: data/ID hold between results, valid is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data  <= '0;
            m_id    <= '0;
            m_valid <= '0;
        end else if (cke) begin
            if (w_tag_valid) begin
                m_data <= w_mul_data;
                m_id   <= r_id_pipe[LATENCY-1];
            end
            m_valid <= w_tag_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_id_pipe[LATENCY-1])
                                   : '0;
        end
    end

`ifdef ELIXIRCHIP_ES1_SPU_MUL_SHARER_STAT_EN
    logic [NUM_REQ-1:0][31:0] r_issue_count;

    // Per-requester accept counters, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_count <= '0;
        end else if (cke) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i] && (r_issue_count[i] != c_stat_sat_limit)) begin
                    r_issue_count[i] <= r_issue_count[i] + 32'd1;
                end
            end
        end
    end

    assign m_issue_count = r_issue_count;
`endif

endmodule
`default_nettype wire
